clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised multi-channel programmable clock/tick divider in the soc_clk domain.
- Replaces hardwired fixed-ratio dividers such as the 50 MHz to 1 MHz RTC divider in the FPGA top level.
- Each channel produces a registered divided clock and a one-cycle tick strobe.
- Divisors can be changed at runtime without glitches; a global sync input phase-aligns all channels.

Parameters:
- NumChannels, 2, number of independent divider channels.
- DivWidth, 16, width of the per-channel period divisor.
- DefaultDiv, 50, divisor loaded into every channel at reset; must be >= 2.

Ports:
- soc_clk  in  1  system clock.
- rst_n  in  1  reset.
- en_i  in  NumChannels  per-channel enable.
- sync_i  in  1  restart all enabled channels at phase 0.
- div_i  in  NumChannels*DivWidth  new divisor per channel (channel k at bits [k*DivWidth +: DivWidth]).
- div_valid_i  in  NumChannels  divisor update request.
- div_ready_o  out  NumChannels  channel can accept a divisor.
- clk_o  out  NumChannels  divided clock (registered).
- tick_o  out  NumChannels  one-cycle strobe coincident with each rising edge of clk_o.

Interface:
- Reset rst_n is asynchronous, active-low; clock is soc_clk.

Behaviour:
- Reset values (per channel): cnt_q=0, D=DefaultDiv, pending=0, clk_o=0, tick_o=0, div_ready_o=1.
- Derived values: H = D - floor(D/2) is the high-phase length; low phase is floor(D/2). D=50 gives 25/25; D=5 gives 3/2.
- en_i=0:
  - cnt_q<=0, clk_o<=0, tick_o<=0.
  - A pending divisor is applied on the next cycle.
- en_i=1, no sync:
  - cnt_q <= (cnt_q==D-1) ? 0 : cnt_q+1.
  - clk_o <= (cnt_q < H).
  - tick_o <= (cnt_q == 0).
  - First cycle en_i is sampled high (cnt_q=0): next cycle clk_o=1 and tick_o=1.
  - Period is exactly D cycles; tick_o is high exactly once per period.
- Divisor handshake:
  - Transfer occurs when div_valid_i && div_ready_o.
  - Value is latched into a shadow register; values < 2 are clamped to 2.
  - pending<=1 and div_ready_o<=0 from the next cycle.
  - Shadow is applied (D<=shadow, pending<=0) in the cycle cnt_q==D-1 with en_i=1, so the new period starts on a clean boundary. It is also applied on sync_i, or while en_i=0.
  - div_ready_o returns to 1 the cycle after application.
  - Valid while not ready is ignored (no queueing).
  - clk_o never produces a high or low phase shorter than min(H_old,H_new) or min(floor(D_old/2),floor(D_new/2)).
- sync_i=1 (all enabled channels, overrides wrap):
  - cnt_q<=0, clk_o<=0, tick_o<=0; pending divisor applied.
  - Next cycle clk_o=1 and tick_o=1 on every enabled channel simultaneously.
  - Disabled channels are unaffected.
- Simultaneous events:
  - sync_i has priority over wrap and counting.
  - Handshake acceptance in the same cycle as the application of a previous value is impossible, since ready=0 while pending.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values, D=DefaultDiv, and any pending update is discarded.
- Widths: cnt_q is DivWidth bits; D-1 is computed without wrap because D>=2.

Optional Feature:
- Macro: CLK_DIV_FRAC_EN.
- When defined:
  - Adds parameter FracWidth (default 8) and input frac_i of width NumChannels*FracWidth, shadowed and applied together with div_i on the same handshake.
  - Each channel keeps a FracWidth accumulator. At every wrap, acc <= acc + frac.
  - On carry-out, the next period is D+1 cycles, with the extra cycle added to the low phase.
  - Average period = D + frac/2^FracWidth. The accumulator is cleared by reset, sync_i and en_i=0.
- When undefined: no frac_i port or accumulator; periods are exactly D.

Test Plan:
- Reset, en_i=1 on ch0, DefaultDiv=50 -> clk_o 25 cycles high / 25 low; tick_o every 50 cycles, first one 1 cycle after enable.
- ch0 running D=50; handshake div=10 at cnt_q=7 -> div_ready_o=0 until the wrap at cnt_q=49. Next period 10 cycles (5/5); div_ready_o=1 the cycle after the wrap.
- div=0 and div=1 accepted -> clamped, period 2 (1 high / 1 low); div=5 -> 3 high / 2 low.
- ch0 D=6, ch1 D=10, both enabled; pulse sync_i -> both tick_o high in the same cycle one cycle later, then every 6 and 10 cycles respectively. A disabled ch2 stays 0.
- Deassert rst_n mid-period with a pending update -> outputs 0 immediately; after release and enable, period 50 (pending value discarded).
- CLK_DIV_FRAC_EN: D=50, frac=128 (FracWidth=8) -> periods alternate 50 and 51 and average 50.5; frac=0 -> constant 50.

Source files
------------

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi
// Description : Multi-channel programmable clock / tick divider (soc_clk
//               domain). Each channel produces a registered divided clock
//               whose high phase is D - floor(D/2) cycles and low phase is
//               floor(D/2) cycles, plus a one-cycle tick coincident with
//               every rising edge of that clock. Divisors are updated via a
//               valid/ready handshake and take effect only on a period
//               boundary (or on sync / while disabled), so no runt phases
//               are generated. sync_i restarts all enabled channels at
//               phase 0 simultaneously.
//               Optional build macro CLK_DIV_FRAC_EN adds a fractional
//               accumulator per channel (frac_i, FracWidth bits) that
//               stretches the low phase by one cycle on each carry-out.
// Ports       : soc_clk      - system clock
//               rst_n        - asynchronous active-low reset
//               en_i         - per-channel enable
//               sync_i       - restart all enabled channels at phase 0
//               div_i        - per-channel divisor, channel k at [k*DivWidth +: DivWidth]
//               frac_i       - per-channel fraction (CLK_DIV_FRAC_EN only)
//               div_valid_i  - per-channel divisor update request
//               div_ready_o  - per-channel "can accept a divisor"
//               clk_o        - per-channel divided clock (registered)
//               tick_o       - per-channel one-cycle strobe at clk_o rise
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
    parameter int NumChannels = 2,
    parameter int DivWidth    = 16,
    parameter int DefaultDiv  = 50
`ifdef CLK_DIV_FRAC_EN
    ,
    parameter int FracWidth   = 8
`endif
) (
    input  logic                            soc_clk,
    input  logic                            rst_n,
    input  logic [NumChannels-1:0]          en_i,
    input  logic                            sync_i,
    input  logic [NumChannels*DivWidth-1:0] div_i,
`ifdef CLK_DIV_FRAC_EN
    input  logic [NumChannels*FracWidth-1:0] frac_i,
`endif
    input  logic [NumChannels-1:0]          div_valid_i,
    output logic [NumChannels-1:0]          div_ready_o,
    output logic [NumChannels-1:0]          clk_o,
    output logic [NumChannels-1:0]          tick_o
);

    localparam logic [DivWidth-1:0] c_ONE         = DivWidth'(1);
    localparam logic [DivWidth-1:0] c_MIN_DIV     = DivWidth'(2);
    localparam logic [DivWidth-1:0] c_DEFAULT_DIV = DivWidth'(DefaultDiv);
`ifdef CLK_DIV_FRAC_EN
    localparam logic [DivWidth:0]   c_ONE_X       = (DivWidth + 1)'(1);
`endif

    for (genvar k = 0; k < NumChannels; k++) begin : g_ch
        logic [DivWidth-1:0] cnt_q, cnt_d;
        logic [DivWidth-1:0] div_q, div_d;
        logic [DivWidth-1:0] shadow_q, shadow_d;
        logic                pending_q, pending_d;
        logic                clk_q, clk_d;
        logic                tick_q, tick_d;

        logic [DivWidth-1:0] w_div_req;
        logic [DivWidth-1:0] w_high;
        logic                w_wrap;
        logic                w_accept;
        logic                w_restart;
        logic                w_apply;

`ifdef CLK_DIV_FRAC_EN
        logic [FracWidth-1:0] acc_q, acc_d;
        logic [FracWidth-1:0] frac_q, frac_d;
        logic [FracWidth-1:0] frac_sh_q, frac_sh_d;
        logic                 ext_q, ext_d;
        logic [FracWidth:0]   w_acc_sum;

        assign w_acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
        // A carried period runs one extra count (cnt reaches D); since
        // cnt >= H there, the extra cycle lands in the low phase.
        assign w_wrap    = ({1'b0, cnt_q} + c_ONE_X) ==
                           ({1'b0, div_q} + {{DivWidth{1'b0}}, ext_q});
`else
        // D >= 2 always, so D-1 cannot wrap.
        assign w_wrap    = (cnt_q == (div_q - c_ONE));
`endif

        assign w_div_req = div_i[k*DivWidth +: DivWidth];
        assign w_high    = div_q - (div_q >> 1);
        // Ready is simply "nothing pending": it drops the cycle after a
        // transfer and rises the cycle after the shadow is applied.
        assign w_accept  = div_valid_i[k] && !pending_q;
        assign w_restart = !en_i[k] || sync_i;
        // Updates land only on a period boundary, a sync, or while idle,
        // which is what keeps clk_o free of shortened phases.
        assign w_apply   = pending_q && (w_restart || w_wrap);

        always_comb begin
            cnt_d     = cnt_q;
            div_d     = div_q;
            shadow_d  = shadow_q;
            pending_d = pending_q;
            clk_d     = clk_q;
            tick_d    = tick_q;
`ifdef CLK_DIV_FRAC_EN
            acc_d     = acc_q;
            frac_d    = frac_q;
            frac_sh_d = frac_sh_q;
            ext_d     = ext_q;
`endif

            if (w_apply) begin
                div_d     = shadow_q;
                pending_d = 1'b0;
`ifdef CLK_DIV_FRAC_EN
                frac_d    = frac_sh_q;
`endif
            end

            // w_accept and w_apply are mutually exclusive (pending gates both).
            if (w_accept) begin
                shadow_d  = (w_div_req < c_MIN_DIV) ? c_MIN_DIV : w_div_req;
                pending_d = 1'b1;
`ifdef CLK_DIV_FRAC_EN
                frac_sh_d = frac_i[k*FracWidth +: FracWidth];
`endif
            end

            if (w_restart) begin
                // Disabled, or sync: park at phase 0 so the next enabled
                // cycle emits the first rising edge.
                cnt_d  = '0;
                clk_d  = 1'b0;
                tick_d = 1'b0;
`ifdef CLK_DIV_FRAC_EN
                acc_d  = '0;
                ext_d  = 1'b0;
`endif
            end else begin
                cnt_d  = w_wrap ? '0 : (cnt_q + c_ONE);
                clk_d  = (cnt_q < w_high);
                tick_d = (cnt_q == '0);
`ifdef CLK_DIV_FRAC_EN
                if (w_wrap) begin
                    {ext_d, acc_d} = w_acc_sum;
                end
`endif
            end
        end

        always_ff @(posedge soc_clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= '0;
                div_q     <= c_DEFAULT_DIV;
                shadow_q  <= c_DEFAULT_DIV;
                pending_q <= 1'b0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
`ifdef CLK_DIV_FRAC_EN
                acc_q     <= '0;
                frac_q    <= '0;
                frac_sh_q <= '0;
                ext_q     <= 1'b0;
`endif
            end else begin
                cnt_q     <= cnt_d;
                div_q     <= div_d;
                shadow_q  <= shadow_d;
                pending_q <= pending_d;
                clk_q     <= clk_d;
                tick_q    <= tick_d;
`ifdef CLK_DIV_FRAC_EN
                acc_q     <= acc_d;
                frac_q    <= frac_d;
                frac_sh_q <= frac_sh_d;
                ext_q     <= ext_d;
`endif
            end
        end

        assign div_ready_o[k] = !pending_q;
        assign clk_o[k]       = clk_q;
        assign tick_o[k]      = tick_q;
    end : g_ch

endmodule : clk_div_multi
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_multi
// Description : Self-checking bench for clk_div_multi (3 channels, 16-bit
//               divisors, default divisor 50). A period-level model predicts
//               clk_o / tick_o / div_ready_o every cycle from the absolute
//               start time and length of each channel's current period;
//               directed scenarios add hand-computed phase-length checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int NCH = 3;
    localparam int DW  = 16;
    localparam int FW  = 8;

    logic               soc_clk;
    logic               rst_n;
    logic [NCH-1:0]     en_i;
    logic               sync_i;
    logic [NCH*DW-1:0]  div_i;
    logic [NCH-1:0]     div_valid_i;
    logic [NCH-1:0]     div_ready_o;
    logic [NCH-1:0]     clk_o;
    logic [NCH-1:0]     tick_o;
`ifdef CLK_DIV_FRAC_EN
    logic [NCH*FW-1:0]  frac_i;
`endif

    int total = 0;
    int bad   = 0;

    clk_div_multi #(
        .NumChannels (NCH),
        .DivWidth    (DW),
        .DefaultDiv  (50)
`ifdef CLK_DIV_FRAC_EN
        ,
        .FracWidth   (FW)
`endif
    ) u_dut (
        .soc_clk     (soc_clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .sync_i      (sync_i),
        .div_i       (div_i),
`ifdef CLK_DIV_FRAC_EN
        .frac_i      (frac_i),
`endif
        .div_valid_i (div_valid_i),
        .div_ready_o (div_ready_o),
        .clk_o       (clk_o),
        .tick_o      (tick_o)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Period-level model: each running channel has an absolute cycle at
    // which its current period began, that period's divisor and length.
    // ------------------------------------------------------------------
    int m_D[NCH], m_sh[NCH], m_fr[NCH], m_fsh[NCH];
    int m_start[NCH], m_len[NCH], m_perD[NCH], m_acc[NCH];
    bit m_pend[NCH], m_run[NCH];
    logic [NCH-1:0] e_clk, e_tick, e_rdy;
    int n = 0;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_D[c] = 50; m_sh[c] = 50; m_fr[c] = 0; m_fsh[c] = 0;
            m_pend[c] = 1'b0; m_run[c] = 1'b0; m_acc[c] = 0;
            m_start[c] = 0; m_len[c] = 50; m_perD[c] = 50;
        end
        e_clk = '0; e_tick = '0; e_rdy = '1;
    endtask

    task automatic model_apply(input int c);
        if (m_pend[c]) begin
            m_D[c] = m_sh[c]; m_fr[c] = m_fsh[c]; m_pend[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit take;
            int req, pos, carry;
            take = div_valid_i[c] && !m_pend[c];
            req  = int'(div_i[c*DW +: DW]);
            if (req < 2) req = 2;
            if (!en_i[c]) begin
                model_apply(c);
                m_run[c] = 1'b0; m_acc[c] = 0;
                e_clk[c] = 1'b0; e_tick[c] = 1'b0;
            end else if (sync_i) begin
                model_apply(c);
                m_run[c] = 1'b1; m_start[c] = n + 1;
                m_perD[c] = m_D[c]; m_len[c] = m_D[c]; m_acc[c] = 0;
                e_clk[c] = 1'b0; e_tick[c] = 1'b0;
            end else begin
                if (!m_run[c]) begin
                    m_run[c] = 1'b1; m_start[c] = n;
                    m_perD[c] = m_D[c]; m_len[c] = m_D[c]; m_acc[c] = 0;
                end
                pos = n - m_start[c];
                e_clk[c]  = (pos < m_perD[c] - m_perD[c] / 2);
                e_tick[c] = (pos == 0);
                if (pos == m_len[c] - 1) begin
                    carry = 0;
`ifdef CLK_DIV_FRAC_EN
                    m_acc[c] += m_fr[c];
                    if (m_acc[c] >= (1 << FW)) begin
                        carry = 1; m_acc[c] -= (1 << FW);
                    end
`endif
                    model_apply(c);
                    m_start[c] = n + 1; m_perD[c] = m_D[c]; m_len[c] = m_D[c] + carry;
                end
            end
            if (take) begin
                m_pend[c] = 1'b1; m_sh[c] = req;
`ifdef CLK_DIV_FRAC_EN
                m_fsh[c] = int'(frac_i[c*FW +: FW]);
`endif
            end
            e_rdy[c] = !m_pend[c];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge soc_clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
            n++;
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge soc_clk);
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("ch%0d clk_o t=%0t", c, $time),  int'(clk_o[c]),       int'(e_clk[c]));
                chk($sformatf("ch%0d tick_o t=%0t", c, $time), int'(tick_o[c]),      int'(e_tick[c]));
                chk($sformatf("ch%0d ready t=%0t", c, $time),  int'(div_ready_o[c]), int'(e_rdy[c]));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic logic [NCH*DW-1:0] pk(input int d0, input int d1, input int d2);
        return {DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    task automatic hs(input logic [NCH-1:0] m, input logic [NCH*DW-1:0] dv);
        div_i = dv; div_valid_i = m;
        @(negedge soc_clk);
        div_valid_i = '0;
    endtask

    task automatic wait_rdy(input logic [NCH-1:0] m);
        int g = 0;
        while (((div_ready_o & m) != m) && g < 300) begin
            @(negedge soc_clk); g++;
        end
        chk("ready wait bound", int'(g < 300), 1);
    endtask

    // Waits for the next tick, then counts high/low cycles of one period.
    task automatic meas(input int ch, output int hi, output int lo);
        int g = 0;
        hi = 0; lo = 0;
        while (!tick_o[ch] && g < 300) begin
            @(negedge soc_clk); g++;
        end
        do begin
            if (clk_o[ch]) hi++; else lo++;
            @(negedge soc_clk); g++;
        end while (!tick_o[ch] && g < 300);
    endtask

    initial begin
        int hi, lo;
        int p[5];
        rst_n = 1'b0; en_i = '0; sync_i = 1'b0; div_i = '0; div_valid_i = '0;
`ifdef CLK_DIV_FRAC_EN
        frac_i = '0;
`endif
        repeat (3) @(negedge soc_clk);
        chk("reset clk_o",  int'(clk_o), 0);
        chk("reset tick_o", int'(tick_o), 0);
        chk("reset ready",  int'(div_ready_o), 7);
        rst_n = 1'b1;
        @(negedge soc_clk);

        // Default divisor 50 on ch0.
        en_i = 3'b001;
        @(negedge soc_clk);
        chk("first tick", int'(tick_o[0]), 1);
        chk("first clk",  int'(clk_o[0]), 1);
        meas(0, hi, lo);
        chk("D50 high", hi, 25);
        chk("D50 low",  lo, 25);

        // Now at phase 0; request D=10 while cnt_q=7.
        repeat (6) @(negedge soc_clk);
        hs(3'b001, pk(10, 0, 0));
        chk("ready low after accept", int'(div_ready_o[0]), 0);
        meas(0, hi, lo);
        chk("D10 high", hi, 5);
        chk("D10 low",  lo, 5);

        // Clamped divisors and an odd divisor.
        hs(3'b001, pk(0, 0, 0)); wait_rdy(3'b001); meas(0, hi, lo);
        chk("div0 high", hi, 1); chk("div0 low", lo, 1);
        hs(3'b001, pk(1, 0, 0)); wait_rdy(3'b001); meas(0, hi, lo);
        chk("div1 high", hi, 1); chk("div1 low", lo, 1);
        hs(3'b001, pk(5, 0, 0)); wait_rdy(3'b001); meas(0, hi, lo);
        chk("div5 high", hi, 3); chk("div5 low", lo, 2);

        // Sync alignment: ch0 D=6, ch1 D=10, ch2 disabled.
        hs(3'b011, pk(6, 10, 0)); wait_rdy(3'b011);
        en_i = 3'b011;
        repeat (3) @(negedge soc_clk);
        sync_i = 1'b1;
        @(negedge soc_clk);
        sync_i = 1'b0;
        chk("sync cycle tick", int'(tick_o), 0);
        @(negedge soc_clk);
        chk("post-sync tick", int'(tick_o), 3);
        chk("post-sync clk",  int'(clk_o), 3);
        repeat (6) @(negedge soc_clk);
        chk("ch0 tick at +6", int'(tick_o), 1);
        repeat (4) @(negedge soc_clk);
        chk("ch1 tick at +10", int'(tick_o), 2);
        chk("ch2 idle", int'(clk_o[2]), 0);

        // Asynchronous reset with a pending update.
        en_i = 3'b001;
        hs(3'b001, pk(20, 0, 0));
        chk("pending before reset", int'(div_ready_o[0]), 0);
        repeat (2) @(negedge soc_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset clk_o",  int'(clk_o), 0);
        chk("async reset tick_o", int'(tick_o), 0);
        chk("async reset ready",  int'(div_ready_o), 7);
        repeat (2) @(negedge soc_clk);
        #2 rst_n = 1'b1;
        meas(0, hi, lo);
        chk("post-reset high", hi, 25); chk("post-reset low", lo, 25);
        meas(0, hi, lo);
        chk("discarded pending high", hi, 25); chk("discarded pending low", lo, 25);

`ifdef CLK_DIV_FRAC_EN
        // D=50, frac=128/256: after one settling period, 50/51 alternate.
        frac_i = {FW'(0), FW'(0), FW'(128)};
        hs(3'b001, pk(50, 0, 0)); wait_rdy(3'b001);
        for (int i = 0; i < 5; i++) begin
            meas(0, hi, lo); p[i] = hi + lo;
        end
        chk("frac B", p[1], 50); chk("frac C", p[2], 51);
        chk("frac D", p[3], 50); chk("frac E", p[4], 51);
        chk("frac sum4", p[1] + p[2] + p[3] + p[4], 202);
        frac_i = '0;
        hs(3'b001, pk(50, 0, 0)); wait_rdy(3'b001);
        for (int i = 0; i < 3; i++) begin
            meas(0, hi, lo); p[i] = hi + lo;
        end
        chk("frac0 period a", p[1], 50); chk("frac0 period b", p[2], 50);
`else
        p[0] = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_clk_div_multi
`default_nettype wire
